// File: rtl/video_capture_ctrl.sv
// video_capture_ctrl: gates camera href/vsync into whole frames and checks line/frame geometry and back-pressure.
// Define CAPTURE_STATS_EN to implement the 16-bit frame_cnt/drop_cnt statistics counters.
module video_capture_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = 12
) (
  input  logic                  piexl_clk,
  input  logic                  rst_n,
  input  logic                  href,
  input  logic                  vsync,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  href_o,
  output logic                  vsync_o,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  m_axis_tready,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            frame_num,
  input  logic                  clr_err,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  line_len_err,
  output logic                  frame_len_err,
  output logic                  ovf_err,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);
  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DROP} state_t;
  state_t state, state_n;
  logic vsync_d, href_d, stop_pend, pass, done, drop, arm;
  logic vs_rise, hr_fall, ovf, last, in_act;
  logic [CNT_W-1:0] pix_cnt, line_cnt, lines;
  logic [7:0] seen;
  assign vs_rise = vsync & ~vsync_d;
  assign hr_fall = ~href & href_d;
  assign ovf     = href_o & ~m_axis_tready;
  assign in_act  = state == ACTIVE;
  assign busy    = state != IDLE;
  // seen counts completed and dropped frames alike, so drops consume the frame_num budget
  assign last    = stop_pend | stop | (frame_num != 8'd0 && seen + 8'd1 == frame_num);
  assign lines   = line_cnt + CNT_W'(hr_fall && line_cnt != '1);
  always_comb begin
    state_n = state;
    pass    = 1'b0;
    done    = 1'b0;
    drop    = 1'b0;
    arm     = 1'b0;
    case (state)
      IDLE: if (start && !stop) begin
        state_n = ARM;
        arm     = 1'b1;
      end
      ARM: if (stop) state_n = IDLE;
        else if (vs_rise) begin
          state_n = ACTIVE;
          pass    = 1'b1;
        end
      ACTIVE: if (vs_rise) begin
        done    = 1'b1;
        state_n = last ? IDLE : ACTIVE;
        pass    = !last;
      end else if (ovf) state_n = DROP;
        else pass = 1'b1;
      default: if (vs_rise) begin
        drop    = 1'b1;
        state_n = last ? IDLE : ACTIVE;
        pass    = !last;
      end
    endcase
  end
  always_ff @(posedge piexl_clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      vsync_d       <= 1'b0;
      href_d        <= 1'b0;
      href_o        <= 1'b0;
      vsync_o       <= 1'b0;
      data_out      <= '0;
      frame_done    <= 1'b0;
      stop_pend     <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      seen          <= '0;
      line_len_err  <= 1'b0;
      frame_len_err <= 1'b0;
      ovf_err       <= 1'b0;
    end else begin
      state         <= state_n;
      vsync_d       <= vsync;
      href_d        <= href;
      href_o        <= href & pass;
      vsync_o       <= vsync & pass;
      data_out      <= data_in;
      frame_done    <= done;
      stop_pend     <= state_n != IDLE && (stop_pend || stop);
      pix_cnt       <= (!in_act || hr_fall) ? '0 : pix_cnt + CNT_W'(href && pix_cnt != '1);
      line_cnt      <= (!in_act || vs_rise) ? '0 : lines;
      seen          <= arm ? 8'd0 : seen + 8'(done | drop);
      line_len_err  <= (line_len_err & ~clr_err) | (in_act & hr_fall & (pix_cnt != CNT_W'(IMG_WIDTH)));
      frame_len_err <= (frame_len_err & ~clr_err) | (done & (lines != CNT_W'(IMG_HEIGHT)));
      ovf_err       <= (ovf_err & ~clr_err) | ovf;
    end
`ifdef CAPTURE_STATS_EN
  logic [15:0] fc, dc;
  always_ff @(posedge piexl_clk or negedge rst_n)
    if (!rst_n) begin
      fc <= '0;
      dc <= '0;
    end else begin
      fc <= arm ? 16'd0 : fc + 16'(done);
      dc <= arm ? 16'd0 : dc + 16'(drop);
    end
  assign frame_cnt = fc;
  assign drop_cnt  = dc;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif
endmodule

// File: tb/tb_video_capture_ctrl.sv
// tb_video_capture_ctrl: directed frame sequences with a per-cycle output scoreboard for video_capture_ctrl.
module tb_video_capture_ctrl;
  localparam int DW = 10;
  localparam int W  = 8;
  localparam int H  = 4;
`ifdef CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic piexl_clk = 1'b0;
  logic rst_n = 1'b0;
  logic href = 1'b0, vsync = 1'b0, m_axis_tready = 1'b1;
  logic start = 1'b0, stop = 1'b0, clr_err = 1'b0;
  logic [7:0] frame_num = 8'd0;
  logic [DW-1:0] data_in = '0, data_out;
  logic href_o, vsync_o, busy, frame_done, line_len_err, frame_len_err, ovf_err;
  logic [15:0] frame_cnt, drop_cnt;
  logic [DW+2:0] exp_q[$];
  int checks = 0, failures = 0;
  int ev_l = -1, ev_p = -1, ev_k = 0;
  video_capture_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(12)) dut (
    .piexl_clk(piexl_clk), .rst_n(rst_n), .href(href), .vsync(vsync), .data_in(data_in),
    .href_o(href_o), .vsync_o(vsync_o), .data_out(data_out), .m_axis_tready(m_axis_tready),
    .start(start), .stop(stop), .frame_num(frame_num), .clr_err(clr_err), .busy(busy),
    .frame_done(frame_done), .line_len_err(line_len_err), .frame_len_err(frame_len_err),
    .ovf_err(ovf_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );
  always #5 piexl_clk = ~piexl_clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // one pixel clock: drive inputs, queue the expected registered outputs, compare after the edge
  task automatic step(input logic h, input logic v, input logic fwd, input logic fd);
    logic [DW+2:0] g, e;
    href = h;
    vsync = v;
    data_in = DW'($urandom);
    exp_q.push_back({h & fwd, v & fwd, fd, data_in});
    @(posedge piexl_clk);
    #1;
    g = {href_o, vsync_o, frame_done, data_out};
    e = exp_q.pop_front();
    chk("stream", 32'(g), 32'(e));
  endtask
  task automatic pulse(input logic st, input logic sp, input logic clr);
    start = st;
    stop = sp;
    clr_err = clr;
    step(0, 0, 0, 0);
    start = 0;
    stop = 0;
    clr_err = 0;
  endtask
  // frame: optional 2-cycle vsync, blanking, nl lines (short lines flagged in smask), 2-cycle line gaps
  task automatic frame(input int nl, input int smask, input bit fwd_in, input bit fd, input bit vs);
    bit f;
    bit ev;
    int w;
    f = fwd_in;
    if (vs) begin
      step(0, 1, f, fd);
      step(0, 1, f, 0);
    end
    step(0, 0, f, 0);
    step(0, 0, f, 0);
    for (int l = 0; l < nl; l++) begin
      w = smask[l] ? W - 1 : W;
      for (int p = 0; p < w + 2; p++) begin
        ev = (l == ev_l && p == ev_p);
        if (ev && ev_k == 1) stop = 1;
        if (ev && ev_k == 2) begin
          m_axis_tready = 0;
          f = 0;
        end
        if (ev && ev_k == 3) clr_err = 1;
        step(p < w, 0, f, 0);
        stop = 0;
        m_axis_tready = 1;
        clr_err = 0;
        if (ev && ev_k == 3) begin
          chk("clr_new_lerr", line_len_err, 1);
          chk("clr_old_ferr", frame_len_err, 0);
        end
      end
    end
    ev_l = -1;
  endtask
  task automatic set_ev(input int l, input int p, input int k);
    ev_l = l;
    ev_p = p;
    ev_k = k;
  endtask
  initial begin
    repeat (2) @(posedge piexl_clk);
    #1;
    chk("rst_outs", {href_o, vsync_o, data_out, frame_done, busy, line_len_err, frame_len_err, ovf_err}, 0);
    chk("rst_cnts", {frame_cnt, drop_cnt}, 0);
    rst_n = 1;
    // single-shot two frames, armed mid-frame
    frame_num = 8'd2;
    pulse(1, 0, 0);
    chk("a_busy_arm", busy, 1);
    frame(2, 0, 0, 0, 0);
    frame(H, 0, 1, 0, 1);
    frame(H, 0, 1, 1, 1);
    frame(H, 0, 0, 1, 1);
    chk("a_busy_end", busy, 0);
    chk("a_frame_cnt", frame_cnt, STATS ? 2 : 0);
    chk("a_errs", {line_len_err, frame_len_err, ovf_err}, 0);
    // continuous, stop mid-line in frame 3
    frame_num = 8'd0;
    pulse(1, 0, 0);
    frame(H, 0, 1, 0, 1);
    frame(H, 0, 1, 1, 1);
    set_ev(1, 3, 1);
    frame(H, 0, 1, 1, 1);
    chk("b_busy_after_f3", busy, 1);
    frame(H, 0, 0, 1, 1);
    chk("b_busy_end", busy, 0);
    chk("b_frame_cnt", frame_cnt, STATS ? 3 : 0);
    // geometry errors and clr_err
    pulse(1, 0, 0);
    frame(H, 0, 1, 0, 1);
    frame(H + 1, 1, 1, 1, 1);
    chk("c_lerr_set", line_len_err, 1);
    chk("c_ferr_pending", frame_len_err, 0);
    set_ev(0, W - 1, 3);
    frame(H, 1, 1, 1, 1);
    set_ev(1, 3, 1);
    frame(H + 1, 0, 1, 1, 1);
    frame(H, 0, 0, 1, 1);
    chk("c_both_set", {line_len_err, frame_len_err}, 2'b11);
    pulse(0, 0, 1);
    chk("c_both_clr", {line_len_err, frame_len_err}, 2'b00);
    // back-pressure: drop frame 1, forward frame 2
    pulse(1, 0, 0);
    set_ev(1, 3, 2);
    frame(H, 0, 1, 0, 1);
    chk("d_ovf_err", ovf_err, 1);
    frame(H, 0, 1, 0, 1);
    chk("d_drop_cnt", drop_cnt, STATS ? 1 : 0);
    chk("d_frame_cnt0", frame_cnt, 0);
    chk("d_lerr", {line_len_err, frame_len_err}, 0);
    set_ev(2, 0, 1);
    frame(H, 0, 1, 1, 1);
    frame(2, 0, 0, 1, 1);
    chk("d_frame_cnt1", frame_cnt, STATS ? 1 : 0);
    chk("d_busy_end", busy, 0);
    // asynchronous reset mid-ACTIVE
    pulse(1, 0, 0);
    frame(2, 0, 1, 0, 1);
    step(1, 0, 1, 0);
    #2;
    rst_n = 0;
    #1;
    chk("e_rst_async", {href_o, vsync_o, data_out, frame_done, busy, ovf_err}, 0);
    repeat (2) @(posedge piexl_clk);
    #1;
    chk("e_rst_hold", {href_o, vsync_o, data_out, frame_done, busy}, 0);
    rst_n = 1;
    frame(H, 0, 0, 0, 1);
    chk("e_idle_after_rst", busy, 0);
    pulse(1, 0, 0);
    frame(1, 0, 0, 0, 0);
    frame(H, 0, 1, 0, 1);
    set_ev(0, 2, 1);
    frame(H, 0, 1, 1, 1);
    frame(1, 0, 0, 1, 1);
    chk("e_frame_cnt", frame_cnt, STATS ? 1 : 0);
    // start and stop together in IDLE
    pulse(1, 1, 0);
    chk("f_busy", busy, 0);
    frame(1, 0, 0, 0, 1);
    chk("f_busy_later", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
